// File: rtl/life_engine.sv
// rtl/life_engine.sv - Conway B3/S23 grid holder computing one row per clock into a shadow buffer
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   step                request one generation (ignored while busy)
//   clear               zero grid and generation counter; aborts a generation in progress
//   wr_en/wr_row/wr_col/wr_val  single-cell edit, accepted only when idle and in range
//   grid                registered live grid, grid[r][c] = cell at row r, column c
//   busy                high while a generation is in progress
//   done                one-cycle pulse on the commit edge
//   gen                 committed generation count (wraps)
module life_engine #(
  parameter int ROWS  = 15,
  parameter int COLS  = 20,
  parameter int WRAP  = 1,
  parameter int GEN_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      step,
  input  logic                      clear,
  input  logic                      wr_en,
  input  logic [$clog2(ROWS)-1:0]   wr_row,
  input  logic [$clog2(COLS)-1:0]   wr_col,
  input  logic                      wr_val,
  output logic [ROWS-1:0][COLS-1:0] grid,
  output logic                      busy,
  output logic                      done,
  output logic [GEN_W-1:0]          gen
);

  localparam int RW = $clog2(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    COMMIT
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [RW-1:0]             r;
  logic [ROWS-1:0][COLS-1:0] shadow;

  logic do_clear;
  logic do_start;
  logic do_write;
  logic do_row;
  logic do_commit;
  logic wr_in_range;

  assign wr_in_range = (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);

  // Next-state and per-edge actions; clear wins over everything in every state.
  always_comb begin
    state_next = state;
    do_clear   = 1'b0;
    do_start   = 1'b0;
    do_write   = 1'b0;
    do_row     = 1'b0;
    do_commit  = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          do_clear = 1'b1;
        end else if (step) begin
          do_start   = 1'b1;
          state_next = COMPUTE;
        end else if (wr_en && wr_in_range) begin
          do_write = 1'b1;
        end
      end
      COMPUTE: begin
        if (clear) begin
          do_clear   = 1'b1;
          state_next = IDLE;
        end else begin
          do_row = 1'b1;
          if (r == LAST_ROW) begin
            state_next = COMMIT;
          end
        end
      end
      COMMIT: begin
        if (clear) begin
          do_clear   = 1'b1;
        end else begin
          do_commit  = 1'b1;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Neighbour row selection. Rows off the top/bottom either wrap or read as dead.
  logic [RW-1:0]   up_idx;
  logic [RW-1:0]   dn_idx;
  logic            up_ok;
  logic            dn_ok;
  logic [COLS-1:0] row_up;
  logic [COLS-1:0] row_mid;
  logic [COLS-1:0] row_dn;

  always_comb begin
    up_ok  = 1'b1;
    dn_ok  = 1'b1;
    up_idx = r - 1'b1;
    dn_idx = r + 1'b1;
    if (r == '0) begin
      up_idx = LAST_ROW;
      up_ok  = (WRAP != 0);
    end
    if (r == LAST_ROW) begin
      dn_idx = '0;
      dn_ok  = (WRAP != 0);
    end
  end

  assign row_up  = up_ok ? grid[up_idx] : '0;
  assign row_mid = grid[r];
  assign row_dn  = dn_ok ? grid[dn_idx] : '0;

  // Pad each row with one guard column on either side so every column's
  // neighbourhood is a fixed 3-bit window: ext bit c+1 holds column c.
  function automatic logic [COLS+1:0] extend(input logic [COLS-1:0] row);
    logic left;
    logic right;
    left  = (WRAP != 0) ? row[COLS-1] : 1'b0;
    right = (WRAP != 0) ? row[0]      : 1'b0;
    return {right, row, left};
  endfunction

  logic [COLS+1:0] ext_up;
  logic [COLS+1:0] ext_mid;
  logic [COLS+1:0] ext_dn;
  logic [COLS-1:0] next_row;

  assign ext_up  = extend(row_up);
  assign ext_mid = extend(row_mid);
  assign ext_dn  = extend(row_dn);

  for (genvar c = 0; c < COLS; c++) begin : g_cell
    logic [3:0] cnt;
    assign cnt = {3'b0, ext_up[c]}  + {3'b0, ext_up[c+1]}  + {3'b0, ext_up[c+2]}
               + {3'b0, ext_mid[c]}                        + {3'b0, ext_mid[c+2]}
               + {3'b0, ext_dn[c]}  + {3'b0, ext_dn[c+1]}  + {3'b0, ext_dn[c+2]};
    assign next_row[c] = (cnt == 4'd3) | (row_mid[c] & (cnt == 4'd2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      r      <= '0;
      grid   <= '0;
      shadow <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      gen    <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= do_commit;
      if (do_clear) begin
        grid <= '0;
        gen  <= '0;
      end
      if (do_write) begin
        grid[wr_row][wr_col] <= wr_val;
      end
      if (do_start) begin
        r <= '0;
      end
      if (do_row) begin
        shadow[r] <= next_row;
        r         <= r + 1'b1;
      end
      if (do_commit) begin
        grid <= shadow;
        gen  <= gen + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_life_engine.sv
// tb/tb_life_engine.sv - checks two life_engine variants (wrapping / bounded, 16-bit / 2-bit gen) against a whole-generation model
module tb_life_engine;

  localparam int ROWS = 15;
  localparam int COLS = 20;
  localparam int NB   = ROWS * COLS;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        step   = 1'b0;
  logic        clear  = 1'b0;
  logic        wr_en  = 1'b0;
  logic        wr_val = 1'b0;
  logic [3:0]  wr_row = '0;
  logic [4:0]  wr_col = '0;

  logic [ROWS-1:0][COLS-1:0] grid_a;
  logic [ROWS-1:0][COLS-1:0] grid_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [15:0] gen_a;
  logic [1:0]  gen_b;

  int checks = 0;
  int errors = 0;

  // Model: index 0 mirrors the wrapping DUT, index 1 the bounded one.
  bit mg [2][ROWS][COLS];
  int m_busy  = 0;
  bit m_done  = 1'b0;
  int m_gen_a = 0;
  int m_gen_b = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  life_engine #(.ROWS(ROWS), .COLS(COLS), .WRAP(1), .GEN_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .step(step), .clear(clear), .wr_en(wr_en),
    .wr_row(wr_row), .wr_col(wr_col), .wr_val(wr_val),
    .grid(grid_a), .busy(busy_a), .done(done_a), .gen(gen_a)
  );

  life_engine #(.ROWS(ROWS), .COLS(COLS), .WRAP(0), .GEN_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .step(step), .clear(clear), .wr_en(wr_en),
    .wr_row(wr_row), .wr_col(wr_col), .wr_val(wr_val),
    .grid(grid_b), .busy(busy_b), .done(done_b), .gen(gen_b)
  );

  task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual %h required %h", nm, act, req);
    end
  endtask

  function automatic logic [ROWS-1:0][COLS-1:0] pack(input int w);
    logic [ROWS-1:0][COLS-1:0] p;
    for (int rr = 0; rr < ROWS; rr++)
      for (int cc = 0; cc < COLS; cc++)
        p[rr][cc] = mg[w][rr][cc];
    return p;
  endfunction

  function automatic void life(input int w);
    bit nx [ROWS][COLS];
    for (int rr = 0; rr < ROWS; rr++) begin
      for (int cc = 0; cc < COLS; cc++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int y, x;
            if (dr == 0 && dc == 0) continue;
            y = rr + dr;
            x = cc + dc;
            if (w == 0) begin
              y = (y + ROWS) % ROWS;
              x = (x + COLS) % COLS;
            end else if (y < 0 || y >= ROWS || x < 0 || x >= COLS) begin
              continue;
            end
            n += int'(mg[w][y][x]);
          end
        end
        nx[rr][cc] = (n == 3) || (mg[w][rr][cc] && n == 2);
      end
    end
    for (int rr = 0; rr < ROWS; rr++)
      for (int cc = 0; cc < COLS; cc++)
        mg[w][rr][cc] = nx[rr][cc];
  endfunction

  function automatic void model_clear();
    for (int w = 0; w < 2; w++)
      for (int rr = 0; rr < ROWS; rr++)
        for (int cc = 0; cc < COLS; cc++)
          mg[w][rr][cc] = 1'b0;
    m_gen_a = 0;
    m_gen_b = 0;
  endfunction

  // Transaction-level view: a step starts a run of ROWS+1 busy edges, and the
  // whole next generation appears at the final one.
  always @(posedge clk) begin
    if (rst_n) begin
      m_done = 1'b0;
      if (m_busy > 0) begin
        if (clear) begin
          model_clear();
          m_busy = 0;
        end else if (m_busy == ROWS + 1) begin
          life(0);
          life(1);
          m_gen_a = (m_gen_a + 1) % 65536;
          m_gen_b = (m_gen_b + 1) % 4;
          m_done  = 1'b1;
          m_busy  = 0;
        end else begin
          m_busy++;
        end
      end else if (clear) begin
        model_clear();
      end else if (step) begin
        m_busy = 1;
      end else if (wr_en && int'(wr_row) < ROWS && int'(wr_col) < COLS) begin
        mg[0][wr_row][wr_col] = wr_val;
        mg[1][wr_row][wr_col] = wr_val;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("grid_a", grid_a, pack(0));
      chk("grid_b", grid_b, pack(1));
      chk("busy_a", NB'(busy_a), NB'(m_busy > 0));
      chk("busy_b", NB'(busy_b), NB'(m_busy > 0));
      chk("done_a", NB'(done_a), NB'(m_done));
      chk("done_b", NB'(done_b), NB'(m_done));
      chk("gen_a", NB'(gen_a), NB'(m_gen_a));
      chk("gen_b", NB'(gen_b), NB'(m_gen_b));
    end
  end

  task automatic cyc(input bit s, input bit cl, input bit we, input int row, input int col, input bit v);
    step   = s;
    clear  = cl;
    wr_en  = we;
    wr_row = 4'(row);
    wr_col = 5'(col);
    wr_val = v;
    @(posedge clk);
    #1;
    step  = 1'b0;
    clear = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int row, input int col);
    cyc(0, 0, 1, row, col, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    m_busy = 0;
    m_done = 1'b0;
    #1;
    chk("rst_grid_a", grid_a, '0);
    chk("rst_grid_b", grid_b, '0);
    chk("rst_gen_a", NB'(gen_a), '0);
    chk("rst_busy_a", NB'(busy_a), '0);
    chk("rst_done_a", NB'(done_a), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_done(output int bc);
    bit seen;
    bc   = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_a) begin
        seen = 1'b1;
        break;
      end
      if (busy_a) bc++;
    end
    chk("done_seen", NB'(seen), NB'(1));
  endtask

  initial begin
    logic [ROWS-1:0][COLS-1:0] e;
    int bc;
    int dcnt;

    do_reset();
    cmp_en = 1'b1;

    // Blinker oscillation
    wr(7, 9); wr(7, 10); wr(7, 11);
    cyc(1, 0, 0, 0, 0, 0);
    wait_done(bc);
    chk("blinker_busy_cycles", NB'(bc), NB'(16));
    e = '0; e[6][10] = 1'b1; e[7][10] = 1'b1; e[8][10] = 1'b1;
    chk("blinker_vertical", grid_a, e);
    chk("blinker_gen1", NB'(gen_a), NB'(1));
    cyc(1, 0, 0, 0, 0, 0);
    wait_done(bc);
    e = '0; e[7][9] = 1'b1; e[7][10] = 1'b1; e[7][11] = 1'b1;
    chk("blinker_horizontal", grid_a, e);
    chk("blinker_gen2", NB'(gen_a), NB'(2));

    // Reset in the middle of a generation
    cyc(1, 0, 0, 0, 0, 0);
    repeat (5) idle();
    do_reset();

    // Edge behaviour, wrapping vs bounded
    wr(0, 4); wr(0, 5); wr(0, 6);
    cyc(1, 0, 0, 0, 0, 0);
    wait_done(bc);
    e = '0; e[14][5] = 1'b1; e[0][5] = 1'b1; e[1][5] = 1'b1;
    chk("edge_wrap", grid_a, e);
    e = '0; e[0][5] = 1'b1; e[1][5] = 1'b1;
    chk("edge_nowrap", grid_b, e);
    chk("edge_gen_b", NB'(gen_b), NB'(1));

    // Step and write while busy are dropped
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 3, 3, 1);
    @(negedge clk);
    chk("busy_write_dropped", NB'(grid_a[3][3]), '0);
    wait_done(bc);
    dcnt = 1;
    repeat (25) begin
      @(negedge clk);
      if (done_a) dcnt++;
    end
    chk("busy_single_done", NB'(dcnt), NB'(1));
    chk("busy_gen1", NB'(gen_a), NB'(1));
    chk("busy_cell33", NB'(grid_a[3][3]), '0);

    // Clear aborts a generation
    do_reset();
    wr(7, 9); wr(7, 10); wr(7, 11);
    cyc(1, 0, 0, 0, 0, 0);
    wait_done(bc);
    cyc(1, 0, 0, 0, 0, 0);
    repeat (4) idle();
    cyc(0, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("abort_busy", NB'(busy_a), '0);
    chk("abort_grid", grid_a, '0);
    chk("abort_gen", NB'(gen_a), '0);
    dcnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_a || done_b) dcnt++;
    end
    chk("abort_no_done", NB'(dcnt), '0);

    // Still life and generation counter wrap
    do_reset();
    wr(2, 2); wr(2, 3); wr(3, 2); wr(3, 3);
    repeat (3) begin
      cyc(1, 0, 0, 0, 0, 0);
      wait_done(bc);
    end
    e = '0; e[2][2] = 1'b1; e[2][3] = 1'b1; e[3][2] = 1'b1; e[3][3] = 1'b1;
    chk("block_still", grid_a, e);
    chk("block_gen3", NB'(gen_a), NB'(3));
    cyc(1, 0, 0, 0, 0, 0);
    wait_done(bc);
    chk("block_gen4_a", NB'(gen_a), NB'(4));
    chk("block_gen_b_wrap", NB'(gen_b), '0);

    // Randomised traffic, including out-of-range writes and combined strobes
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 9) == 0, $urandom_range(0, 79) == 0,
            $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
            int'($urandom_range(0, 31)), $urandom_range(0, 2) != 0);
      end
    end
    repeat (20) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
